// File: rtl/gpio_conv_bridge_if.sv
// GPIO pair between the MicroBlaze (master) and the convolution bridge (slave).
interface gpio_conv_bridge_if;
  logic [31:0] gpio_o_data_tri_o;
  logic [31:0] gpio_i_data_tri_i;

  modport master (output gpio_o_data_tri_o, input  gpio_i_data_tri_i);
  modport slave  (input  gpio_o_data_tri_o, output gpio_i_data_tri_i);
endinterface

// File: rtl/gpio_conv_bridge.sv
// Toggle-handshaked GPIO command decoder driving an N_CH conv array,
// with a lock-step result FIFO read back through the status word.
module gpio_conv_bridge #(
  parameter int BIT_LEN  = 8,
  parameter int CONV_LEN = 20,
  parameter int M_LEN    = 3,
  parameter int N_CH     = 2,
  parameter int FIFO_AW  = 4,
  parameter int GPIO_D   = 32,
  localparam int KN = M_LEN * M_LEN,
  localparam int KW = (KN > 1) ? $clog2(KN) : 1
) (
  input  logic                     CLK100MHZ,
  input  logic                     ck_rst,
  gpio_conv_bridge_if.slave        gpio,
  output logic [N_CH-1:0]          o_k_we,
  output logic [KW-1:0]            o_k_addr,
  output logic [BIT_LEN-1:0]       o_k_data,
  output logic [N_CH-1:0]          o_pix_valid,
  output logic [BIT_LEN-1:0]       o_pix_data,
  output logic                     o_run,
  input  logic                     i_res_valid,
  input  logic [N_CH*CONV_LEN-1:0] i_res_data,
  output logic [2:0]               o_led
);
  localparam int DW    = N_CH * CONV_LEN;
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW    = FIFO_AW + 1;

  localparam logic [2:0] OP_SRST = 3'd1, OP_KLOAD = 3'd2, OP_PIXEL = 3'd3, OP_RUN = 3'd4,
                         OP_POP  = 3'd5, OP_READ  = 3'd6, OP_STAT  = 3'd7;

  typedef enum logic [1:0] {IDLE, EXEC, RDWAIT, DONE} state_t;

  state_t               state_q, state_d;
  logic                 req_q, req_d, ack_q, ack_d;
  logic [2:0]           op_q, op_d;
  logic [3:0]           ch_q, ch_d;
  logic [BIT_LEN-1:0]   pl_q, pl_d;
  logic [KW-1:0]        kidx_q, kidx_d;
  logic                 run_q, run_d, ovf_q, ovf_d, err_q, err_d;
  logic [23:0]          data_q, data_d;
  logic [N_CH-1:0]      k_we_q, k_we_d, pix_vld_q, pix_vld_d;
  logic [KW-1:0]        k_addr_q, k_addr_d;
  logic [BIT_LEN-1:0]   k_data_q, k_data_d, pix_data_q, pix_data_d;
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DW-1:0]        mem_q [DEPTH];

  logic [GPIO_D-1:0]    cmd_w;
  logic                 unused_pl;
  logic                 ch_ok, full, empty, wr, pop, clr;
  logic [DW-1:0]        head;
  logic [CONV_LEN-1:0]  ch_res;

  assign cmd_w     = gpio.gpio_o_data_tri_o;
  assign unused_pl = ^cmd_w[23:BIT_LEN];
  assign ch_ok     = 32'(ch_q) < N_CH;
  assign full      = cnt_q == CW'(DEPTH);
  assign empty     = cnt_q == '0;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    ch_res = '0;
    for (int c = 0; c < N_CH; c++)
      if (ch_q == 4'(c)) ch_res = head[c*CONV_LEN +: CONV_LEN];
  end

  always_comb begin
    state_d = state_q;  req_d = req_q;  ack_d = ack_q;
    op_d = op_q;  ch_d = ch_q;  pl_d = pl_q;
    kidx_d = kidx_q;  run_d = run_q;  ovf_d = ovf_q;  err_d = err_q;  data_d = data_q;
    k_we_d = '0;  k_addr_d = k_addr_q;  k_data_d = k_data_q;
    pix_vld_d = '0;  pix_data_d = pix_data_q;
    wr_ptr_d = wr_ptr_q;  rd_ptr_d = rd_ptr_q;  cnt_d = cnt_q;
    pop = 1'b0;  clr = 1'b0;  wr = 1'b0;

    case (state_q)
      IDLE: if (cmd_w[28] != req_q) begin
        req_d   = cmd_w[28];
        op_d    = cmd_w[31:29];
        ch_d    = cmd_w[27:24];
        pl_d    = cmd_w[BIT_LEN-1:0];
        state_d = EXEC;
      end
      EXEC: begin
        state_d = DONE;
        case (op_q)
          OP_SRST: begin
            clr = 1'b1;  kidx_d = '0;  ovf_d = 1'b0;  err_d = 1'b0;  run_d = 1'b0;  data_d = '0;
          end
          OP_KLOAD: if (ch_ok) begin
            k_we_d   = N_CH'(1) << ch_q;
            k_addr_d = kidx_q;
            k_data_d = pl_q;
            kidx_d   = (kidx_q == KW'(KN-1)) ? '0 : kidx_q + KW'(1);
          end else err_d = 1'b1;
          OP_PIXEL: if (ch_ok) begin
            pix_vld_d  = N_CH'(1) << ch_q;
            pix_data_d = pl_q;
          end else err_d = 1'b1;
          OP_RUN:  run_d = pl_q[0];
          OP_POP:  if (empty) err_d = 1'b1; else pop = 1'b1;
          OP_READ: begin
            state_d = RDWAIT;
            if (!ch_ok) err_d = 1'b1;
          end
          OP_STAT: data_d = 24'({kidx_q, cnt_q});
          default: ;
        endcase
      end
      RDWAIT: begin
        state_d = DONE;
        if (ch_ok) begin
          if (empty) begin data_d = '0;  err_d = 1'b1; end
          else data_d = 24'($signed(ch_res));
        end
      end
      DONE: begin
        ack_d   = req_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A same-cycle pop frees the slot, so a write into a full FIFO still lands.
    wr = i_res_valid && !clr && (!full || pop);
    if (i_res_valid && !clr && full && !pop) ovf_d = 1'b1;
    if (clr) begin
      wr_ptr_d = '0;  rd_ptr_d = '0;  cnt_d = '0;
    end else begin
      if (wr)  wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
      if (pop) rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      if (wr && !pop)      cnt_d = cnt_q + CW'(1);
      else if (pop && !wr) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge CLK100MHZ or posedge ck_rst) begin
    if (ck_rst) begin
      state_q <= IDLE;  req_q <= 1'b0;  ack_q <= 1'b0;
      op_q <= '0;  ch_q <= '0;  pl_q <= '0;
      kidx_q <= '0;  run_q <= 1'b0;  ovf_q <= 1'b0;  err_q <= 1'b0;  data_q <= '0;
      k_we_q <= '0;  k_addr_q <= '0;  k_data_q <= '0;
      pix_vld_q <= '0;  pix_data_q <= '0;
      wr_ptr_q <= '0;  rd_ptr_q <= '0;  cnt_q <= '0;
    end else begin
      state_q <= state_d;  req_q <= req_d;  ack_q <= ack_d;
      op_q <= op_d;  ch_q <= ch_d;  pl_q <= pl_d;
      kidx_q <= kidx_d;  run_q <= run_d;  ovf_q <= ovf_d;  err_q <= err_d;  data_q <= data_d;
      k_we_q <= k_we_d;  k_addr_q <= k_addr_d;  k_data_q <= k_data_d;
      pix_vld_q <= pix_vld_d;  pix_data_q <= pix_data_d;
      wr_ptr_q <= wr_ptr_d;  rd_ptr_q <= rd_ptr_d;  cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge CLK100MHZ)
    if (wr) mem_q[wr_ptr_q] <= i_res_data;

  assign gpio.gpio_i_data_tri_i = {ack_q, empty, full, ovf_q, err_q, 3'b000, data_q};
  assign o_k_we      = k_we_q;
  assign o_k_addr    = k_addr_q;
  assign o_k_data    = k_data_q;
  assign o_pix_valid = pix_vld_q;
  assign o_pix_data  = pix_data_q;
  assign o_run       = run_q;
  assign o_led       = {ovf_q, run_q, empty};
endmodule
